level_ctrl: RTL and testbench
=============================

LEVEL_CTRL -- requirements
Module: level_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 1000000: idle cycles in ACTIVE (no accepted step) before auto-decay begins; legal range 2..2^24-1.
REQ-002 Parameter DECAY_PERIOD, default 500000: cycles between auto-decrements in DECAY; legal range 2..2^24-1.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 up  input  1  raw asynchronous increment request (level; rising edge = one step).
REQ-006 down  input  1  raw asynchronous decrement request (level; rising edge = one step).
REQ-007 decimal  output  3  registered level 0..7, feeds the thermometer/Gray encoder stage.
REQ-008 enable  output  1  registered; high when state is ACTIVE or DECAY.
REQ-009 state  output  2  registered FSM state: 00 OFF, 01 ACTIVE, 10 DECAY; 11 never driven.
REQ-010 sat  output  1  registered one-cycle pulse when a step is rejected at a limit (up at 7).

Function
REQ-011 up and down SHALL each pass through a 2-flop synchronizer; step events are rising edges of the second flop (vs a third history flop).
REQ-012 A raw input first sampled high at edge N SHALL update decimal/state at edge N+2; outputs stable one cycle later for the encoder.
REQ-013 A raw input held high SHALL produce exactly one step; a new step requires a low of at least one sampled cycle.
REQ-014 Up-edge and down-edge in the same cycle SHALL cancel: decimal unchanged, no sat, but counted as activity (idle timer cleared, DECAY -> ACTIVE).
REQ-015 OFF: decimal=0, enable=0; up-edge -> ACTIVE with decimal=1; down-edge ignored (no sat); timers held at 0.
REQ-016 ACTIVE: up-edge -> decimal+1 if <7, else decimal stays 7 and sat pulses; down-edge -> decimal-1; if result is 0 -> OFF.
REQ-017 ACTIVE: 24-bit idle timer increments each cycle without a step event and clears on any step event (including cancelled pairs).
REQ-018 ACTIVE: idle timer reaching TIMEOUT-1 with no step event that cycle -> DECAY, decay timer cleared; decimal unchanged on entry.
REQ-019 DECAY: 24-bit decay timer increments each cycle; at DECAY_PERIOD-1 it clears and decimal decrements by 1; decrement to 0 -> OFF.
REQ-020 DECAY: any step event -> ACTIVE, applying the step per REQ-016 in the same cycle, idle timer cleared; step wins over a coincident decay tick.
REQ-021 decimal SHALL never wrap: no increment beyond 7, no decrement below 0.
REQ-022 enable SHALL be low in every cycle where decimal=0 and high in every cycle where decimal≠0.
REQ-023 sat SHALL be high for exactly one cycle per rejected up-edge and low otherwise.

Reset
REQ-024 rst high SHALL immediately (no clock required) force state=OFF, decimal=0, enable=0, sat=0, timers=0, synchronizer/history flops=0.
REQ-025 rst asserted mid-operation (any state, any timer value) SHALL abort it; after release the block behaves as fresh from OFF.
REQ-026 An up input already high at rst release SHALL produce one step (history flop reset to 0 sees a rising edge).

Verification (TIMEOUT=8, DECAY_PERIOD=4)
REQ-027 Reset, pulse up once (3 cycles high) -> decimal=1, enable=1, state=01 at edge N+2; no further change while up held.
REQ-028 Nine separate up pulses from OFF -> decimal 1..7, then sat pulses exactly twice, decimal stays 7.
REQ-029 decimal=3 in ACTIVE, no input -> state=10 after 8 idle cycles, then decimal 2,1,0 every 4 cycles, then state=00, enable=0.
REQ-030 In DECAY at decimal=5, up pulse -> state=01, decimal=6, idle timer restarts (no decay for next 8 cycles).
REQ-031 decimal=4, up and down rising in the same clock -> decimal stays 4, sat=0, idle timer cleared.
REQ-032 decimal=6 in DECAY, rst asserted between clock edges -> outputs 0/OFF immediately; after release with up high -> decimal=1 two edges later.

Source files
------------

// File: rtl/level_ctrl.sv
// Level controller: synchronised up/down steps move a 0..7 level, with idle
// timeout into a periodic auto-decay that ends in OFF.
module level_ctrl #(
  parameter int TIMEOUT      = 1000000,
  parameter int DECAY_PERIOD = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up,
  input  logic       down,
  output logic [2:0] decimal,
  output logic       enable,
  output logic [1:0] state,
  output logic       sat
);

  typedef enum logic [1:0] {
    ST_OFF    = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_DECAY  = 2'b10
  } state_t;

  localparam logic [23:0] IDLE_LAST  = 24'(TIMEOUT - 1);
  localparam logic [23:0] DECAY_LAST = 24'(DECAY_PERIOD - 1);
  localparam logic [2:0]  LEVEL_MAX  = 3'd7;

  logic        up_s1_q, up_s1_d, up_s2_q, up_s2_d, up_h_q, up_h_d;
  logic        dn_s1_q, dn_s1_d, dn_s2_q, dn_s2_d, dn_h_q, dn_h_d;
  state_t      state_q, state_d;
  logic [2:0]  decimal_q, decimal_d;
  logic        enable_q, enable_d;
  logic        sat_q, sat_d;
  logic [23:0] idle_q, idle_d;
  logic [23:0] decay_q, decay_d;
  logic        up_evt, dn_evt, up_only, dn_only;

  always_comb begin
    up_s1_d   = up;
    up_s2_d   = up_s1_q;
    up_h_d    = up_s2_q;
    dn_s1_d   = down;
    dn_s2_d   = dn_s1_q;
    dn_h_d    = dn_s2_q;
    up_evt    = up_s2_q & ~up_h_q;
    dn_evt    = dn_s2_q & ~dn_h_q;
    up_only   = up_evt & ~dn_evt;
    dn_only   = dn_evt & ~up_evt;
    state_d   = state_q;
    decimal_d = decimal_q;
    sat_d     = 1'b0;
    idle_d    = idle_q;
    decay_d   = decay_q;

    case (state_q)
      ST_OFF: begin
        idle_d  = '0;
        decay_d = '0;
        if (up_only) begin
          state_d   = ST_ACTIVE;
          decimal_d = 3'd1;
        end
      end

      ST_ACTIVE, ST_DECAY: begin
        if (up_evt || dn_evt) begin
          // Any step (a cancelled pair included) counts as activity and wins
          // over a coincident decay tick.
          state_d = ST_ACTIVE;
          idle_d  = '0;
          decay_d = '0;
          if (up_only) begin
            if (decimal_q != LEVEL_MAX) decimal_d = decimal_q + 3'd1;
            else                        sat_d     = 1'b1;
          end else if (dn_only && decimal_q != 3'd0) begin
            decimal_d = decimal_q - 3'd1;
            if (decimal_q == 3'd1) state_d = ST_OFF;
          end
        end else if (state_q == ST_ACTIVE) begin
          if (idle_q == IDLE_LAST) begin
            state_d = ST_DECAY;
            idle_d  = '0;
            decay_d = '0;
          end else begin
            idle_d = idle_q + 24'd1;
          end
        end else begin
          if (decay_q == DECAY_LAST) begin
            decay_d = '0;
            if (decimal_q != 3'd0) decimal_d = decimal_q - 3'd1;
            if (decimal_q <= 3'd1) state_d = ST_OFF;
          end else begin
            decay_d = decay_q + 24'd1;
          end
        end
      end

      default: begin
        state_d   = ST_OFF;
        decimal_d = 3'd0;
        idle_d    = '0;
        decay_d   = '0;
      end
    endcase

    // Derived from the next level so enable can never disagree with decimal.
    enable_d = (decimal_d != 3'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_s1_q   <= 1'b0;
      up_s2_q   <= 1'b0;
      up_h_q    <= 1'b0;
      dn_s1_q   <= 1'b0;
      dn_s2_q   <= 1'b0;
      dn_h_q    <= 1'b0;
      state_q   <= ST_OFF;
      decimal_q <= 3'd0;
      enable_q  <= 1'b0;
      sat_q     <= 1'b0;
      idle_q    <= '0;
      decay_q   <= '0;
    end else begin
      up_s1_q   <= up_s1_d;
      up_s2_q   <= up_s2_d;
      up_h_q    <= up_h_d;
      dn_s1_q   <= dn_s1_d;
      dn_s2_q   <= dn_s2_d;
      dn_h_q    <= dn_h_d;
      state_q   <= state_d;
      decimal_q <= decimal_d;
      enable_q  <= enable_d;
      sat_q     <= sat_d;
      idle_q    <= idle_d;
      decay_q   <= decay_d;
    end
  end

  assign decimal = decimal_q;
  assign enable  = enable_q;
  assign state   = state_q;
  assign sat     = sat_q;

endmodule

// File: tb/tb_level_ctrl.sv
// Bench for level_ctrl: a per-cycle vector table for basic stepping plus
// directed sequences for saturation, timeout/decay, cancel and async reset.
module tb_level_ctrl;
  localparam int TIMEOUT      = 8;
  localparam int DECAY_PERIOD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       up = 1'b0;
  logic       down = 1'b0;
  logic [2:0] decimal;
  logic       enable;
  logic [1:0] state;
  logic       sat;

  int total = 0;
  int bad = 0;
  int sat_cnt = 0;
  int n;

  typedef struct {
    logic       up;
    logic       dn;
    logic [2:0] dec;
    logic [1:0] st;
    logic       en;
    logic       sat;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  level_ctrl #(.TIMEOUT(TIMEOUT), .DECAY_PERIOD(DECAY_PERIOD)) dut (
    .clk(clk), .rst(rst), .up(up), .down(down),
    .decimal(decimal), .enable(enable), .state(state), .sat(sat)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs, let one rising edge pass, sample just after it.
  task automatic tick(input logic u, input logic d);
    up = u;
    down = d;
    @(posedge clk);
    #1;
    if (sat === 1'b1) sat_cnt++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    up = 1'b0;
    down = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sat_cnt = 0;
  endtask

  // One sampled-high cycle, then two low: the step lands on the third edge.
  task automatic pulse_up();
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic run_until_state(input logic [1:0] s, input int limit, output int cnt);
    cnt = 0;
    while (state !== s && cnt < limit) begin
      tick(1'b0, 1'b0);
      cnt++;
    end
  endtask

  task automatic run_until_dec_change(input int limit, output int cnt);
    logic [2:0] start;
    start = decimal;
    cnt = 0;
    while (decimal === start && cnt < limit) begin
      tick(1'b0, 1'b0);
      cnt++;
    end
  endtask

  initial begin
    // Vector k is driven before edge k and checked just after it.
    vecs[0]  = '{1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 3'd1, 2'd1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 3'd1, 2'd1, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 3'd1, 2'd1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 3'd1, 2'd1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 3'd1, 2'd1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0};

    // Reset state is visible with no clock edge yet.
    #1;
    check("rst_dec", decimal, 0);
    check("rst_state", state, 0);
    check("rst_en", enable, 0);
    check("rst_sat", sat, 0);

    do_reset();
    for (int i = 0; i < 12; i++) begin
      tick(vecs[i].up, vecs[i].dn);
      check($sformatf("vec%0d_dec", i), decimal, vecs[i].dec);
      check($sformatf("vec%0d_state", i), state, vecs[i].st);
      check($sformatf("vec%0d_en", i), enable, vecs[i].en);
      check($sformatf("vec%0d_sat", i), sat, vecs[i].sat);
    end

    // Nine up pulses: 1..7, then two saturation pulses.
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      pulse_up();
      check($sformatf("inc%0d_dec", k), decimal, (k > 7) ? 7 : k);
      check($sformatf("inc%0d_sat", k), sat, (k > 7) ? 1 : 0);
      check($sformatf("inc%0d_state", k), state, 1);
    end
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("sat_count", sat_cnt, 2);
    check("sat_final_dec", decimal, 7);

    // Idle timeout from 3, then decay 2,1,0 every DECAY_PERIOD cycles.
    do_reset();
    repeat (3) pulse_up();
    check("to_start_dec", decimal, 3);
    run_until_state(2'd2, 40, n);
    check("to_idle_cycles", n, TIMEOUT);
    check("to_entry_dec", decimal, 3);
    check("to_entry_en", enable, 1);
    for (int e = 2; e >= 0; e--) begin
      run_until_dec_change(40, n);
      check($sformatf("decay_to%0d_cycles", e), n, DECAY_PERIOD);
      check($sformatf("decay_to%0d_dec", e), decimal, e);
    end
    check("decay_end_state", state, 0);
    check("decay_end_en", enable, 0);

    // Step during DECAY returns to ACTIVE and restarts the idle timer.
    do_reset();
    repeat (5) pulse_up();
    run_until_state(2'd2, 40, n);
    check("wake_pre_state", state, 2);
    pulse_up();
    check("wake_state", state, 1);
    check("wake_dec", decimal, 6);
    repeat (TIMEOUT - 1) tick(1'b0, 1'b0);
    check("wake_hold_state", state, 1);
    check("wake_hold_dec", decimal, 6);
    tick(1'b0, 1'b0);
    check("wake_redecay_state", state, 2);

    // Coincident up/down edges cancel but still clear the idle timer.
    do_reset();
    repeat (4) pulse_up();
    repeat (5) tick(1'b0, 1'b0);
    sat_cnt = 0;
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("cancel_dec", decimal, 4);
    check("cancel_state", state, 1);
    check("cancel_sat", sat_cnt, 0);
    run_until_state(2'd2, 40, n);
    check("cancel_idle_cycles", n, TIMEOUT);

    // Async reset mid-DECAY, released with up already high.
    do_reset();
    repeat (6) pulse_up();
    run_until_state(2'd2, 40, n);
    check("ar_pre_dec", decimal, 6);
    #2;
    up = 1'b1;
    rst = 1'b1;
    #1;
    check("ar_dec", decimal, 0);
    check("ar_state", state, 0);
    check("ar_en", enable, 0);
    check("ar_sat", sat, 0);
    @(negedge clk);
    rst = 1'b0;
    tick(1'b1, 1'b0);
    check("ar_rel1_dec", decimal, 0);
    tick(1'b1, 1'b0);
    check("ar_rel2_dec", decimal, 0);
    tick(1'b1, 1'b0);
    check("ar_rel3_dec", decimal, 1);
    check("ar_rel3_state", state, 1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check("ar_held_dec", decimal, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
